// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants for the instruction encoder and the control unit.
package mips_pkg;

    // Field widths of a 32-bit MIPS instruction word
    localparam int INSTR_W = 32;
    localparam int FMT_W   = 2;
    localparam int OP_W    = 6;
    localparam int REG_W   = 5;
    localparam int SHAMT_W = 5;
    localparam int FUNCT_W = 6;
    localparam int IMM_W   = 16;
    localparam int TGT_W   = 26;

    // Instruction format selectors carried alongside the decoded fields
    localparam logic [FMT_W-1:0] FMT_R   = 2'd0;
    localparam logic [FMT_W-1:0] FMT_I   = 2'd1;
    localparam logic [FMT_W-1:0] FMT_J   = 2'd2;
    localparam logic [FMT_W-1:0] FMT_BAD = 2'd3;

    // Every R-type instruction shares the all-zero opcode
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;

    // Encoder session states
    typedef enum logic [1:0] {
        ENC_IDLE  = 2'd0,
        ENC_LOAD  = 2'd1,
        ENC_WRITE = 2'd2,
        ENC_DONE  = 2'd3
    } enc_state_e;

    // True for the three formats that map onto a real instruction word
    function automatic logic fmt_is_legal(input logic [FMT_W-1:0] fmt);
        return (fmt != FMT_BAD);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: turns a format selector plus decoded fields into a 32-bit MIPS word.
module instr_pack
    import mips_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [5:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Select the field layout for the requested format; R-type ignores op and forces the R opcode
    always_comb begin
        word    = '0;
        illegal = !fmt_is_legal(fmt);
        case (fmt)
            FMT_R:   word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            FMT_I:   word = {op, rs, rt, imm};
            FMT_J:   word = {op, target};
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded field bundles, packs them into MIPS words
// and writes them to consecutive instruction-memory addresses over a stallable port.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err_fmt,
    output logic              err_overflow,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE_PTR  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    enc_state_e        state_q,        state_d;
    logic [ADDR_W-1:0] ptr_q,          ptr_d;
    logic              last_q,         last_d;
    logic [ADDR_W:0]   count_q,        count_d;
    logic              mem_we_q,       mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,     mem_addr_d;
    logic [31:0]       mem_wdata_q,    mem_wdata_d;
    logic              busy_q,         busy_d;
    logic              done_q,         done_d;
    logic              err_fmt_q,      err_fmt_d;
    logic              err_overflow_q, err_overflow_d;

    logic [31:0]       pack_word;
    logic              pack_illegal;

    instr_pack u_pack (
        .fmt     (in_fmt),
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .shamt   (in_shamt),
        .funct   (in_funct),
        .imm     (in_imm),
        .target  (in_target),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    // Session FSM next-state logic: pointer, counter, holding register and sticky flags
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        last_d         = last_q;
        count_d        = count_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        err_fmt_d      = err_fmt_q;
        err_overflow_d = err_overflow_q;

        case (state_q)
            ENC_IDLE, ENC_DONE: begin
                if (start) begin
                    state_d        = ENC_LOAD;
                    ptr_d          = BASE_PTR;
                    count_d        = '0;
                    err_fmt_d      = 1'b0;
                    err_overflow_d = 1'b0;
                end
            end

            ENC_LOAD: begin
                if (in_valid) begin
                    if (pack_illegal) begin
                        err_fmt_d = 1'b1;
                        if (in_last) begin
                            state_d = ENC_DONE;
                        end
                    end else begin
                        mem_wdata_d = pack_word;
                        mem_addr_d  = ptr_q;
                        last_d      = in_last;
                        mem_we_d    = 1'b1;
                        state_d     = ENC_WRITE;
                    end
                end
            end

            ENC_WRITE: begin
                if (mem_ack) begin
                    mem_we_d = 1'b0;
                    count_d  = count_q + COUNT_ONE;
                    ptr_d    = ptr_q + PTR_ONE;
                    if (last_q) begin
                        state_d = ENC_DONE;
                    end else if (&ptr_q) begin
                        state_d        = ENC_DONE;
                        err_overflow_d = 1'b1;
                    end else begin
                        state_d = ENC_LOAD;
                    end
                end
            end

            default: begin
                state_d  = ENC_IDLE;
                mem_we_d = 1'b0;
            end
        endcase

        busy_d = (state_d == ENC_LOAD) || (state_d == ENC_WRITE);
        done_d = (state_d == ENC_DONE);
    end

    // State and registered-output flops; reset abandons any in-flight write immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ENC_IDLE;
            ptr_q          <= BASE_PTR;
            last_q         <= 1'b0;
            count_q        <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_fmt_q      <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            last_q         <= last_d;
            count_q        <= count_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_fmt_q      <= err_fmt_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign in_ready     = (state_q == ENC_LOAD);
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_fmt      = err_fmt_q;
    assign err_overflow = err_overflow_q;
    assign count        = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: packing table, write stalls, session end, illegal
// formats, address-space overflow (on a 2-bit-address instance) and mid-write reset.
module tb_instr_encoder;
    import mips_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [1:0]  in_fmt;
    logic [5:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;
    logic        mem_ack;

    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err_fmt;
    logic        err_overflow;
    logic [8:0]  count;

    logic        ov_in_ready;
    logic        ov_mem_we;
    logic [1:0]  ov_mem_addr;
    logic [31:0] ov_mem_wdata;
    logic        ov_busy;
    logic        ov_done;
    logic        ov_err_fmt;
    logic        ov_err_overflow;
    logic [2:0]  ov_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic        last;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[7];
    vec_t v;
    vec_t bad_v;
    bit   ok;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .busy(busy), .done(done), .err_fmt(err_fmt),
        .err_overflow(err_overflow), .count(count)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_ov (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ov_in_ready),
        .in_fmt(in_fmt), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .in_last(in_last), .mem_we(ov_mem_we), .mem_addr(ov_mem_addr), .mem_wdata(ov_mem_wdata),
        .mem_ack(mem_ack), .busy(ov_busy), .done(ov_done), .err_fmt(ov_err_fmt),
        .err_overflow(ov_err_overflow), .count(ov_count)
    );

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one bundle and hold it until the selected encoder takes it (bounded wait)
    task automatic applyStimulus(input vec_t sv, input bit sel, input string name);
        bit got;
        got       = 1'b0;
        in_fmt    = sv.fmt;
        in_op     = sv.op;
        in_rs     = sv.rs;
        in_rt     = sv.rt;
        in_rd     = sv.rd;
        in_shamt  = sv.shamt;
        in_funct  = sv.funct;
        in_imm    = sv.imm;
        in_target = sv.target;
        in_last   = sv.last;
        in_valid  = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            if ((sel ? ov_in_ready : in_ready) == 1'b1) got = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput({name, "_accepted"}, 32'(got), 32'd1);
    endtask

    // Check the write port of the main encoder in the cycle after a handshake
    task automatic checkWrite(input string name, input logic [7:0] exp_addr, input logic [31:0] exp_word);
        checkOutput({name, "_we"},    32'(mem_we),   32'd1);
        checkOutput({name, "_addr"},  32'(mem_addr), 32'(exp_addr));
        checkOutput({name, "_wdata"}, mem_wdata,     exp_word);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Absolute time limit so a stuck handshake can never hang the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{FMT_R, 6'h3F, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h0000, 26'h0000000, 1'b0, 32'h00221820};
        vecs[1] = '{FMT_R, 6'h00, 5'd8,  5'd9,  5'd10, 5'd4,  6'h00, 16'h1234, 26'h0000000, 1'b0, 32'h01095100};
        vecs[2] = '{FMT_I, 6'h23, 5'd29, 5'd8,  5'd7,  5'd3,  6'h15, 16'h0004, 26'h0000000, 1'b0, 32'h8FA80004};
        vecs[3] = '{FMT_I, 6'h08, 5'd0,  5'd31, 5'd0,  5'd0,  6'h00, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h201FFFFF};
        vecs[4] = '{FMT_J, 6'h02, 5'd31, 5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0000010, 1'b0, 32'h08000010};
        vecs[5] = '{FMT_J, 6'h03, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'hABCD, 26'h3FFFFFF, 1'b0, 32'h0FFFFFFF};
        vecs[6] = '{FMT_R, 6'h15, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h0000, 26'h0000000, 1'b1, 32'h03FFFFFF};
        bad_v   = '{FMT_BAD, 6'h23, 5'd1, 5'd2, 5'd3,  5'd4,  6'h20, 16'h5555, 26'h1555555, 1'b0, 32'h00000000};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ack = 1'b1;
        in_fmt = '0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
        in_funct = '0; in_imm = '0; in_target = '0;

        // Reset state
        #3;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_mem_we",   32'(mem_we),   32'd0);
        checkOutput("rst_busy",     32'(busy),     32'd0);
        checkOutput("rst_done",     32'(done),     32'd0);
        checkOutput("rst_count",    32'(count),    32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table: one session packing every vector, mem_ack tied high
        pulseStart();
        checkOutput("load_busy",  32'(busy),     32'd1);
        checkOutput("load_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(vecs[k], 1'b0, $sformatf("vec%0d", k));
            checkWrite($sformatf("vec%0d", k), 8'(k), vecs[k].exp_word);
            checkOutput($sformatf("vec%0d_ready", k), 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        checkOutput("tbl_done",  32'(done),  32'd1);
        checkOutput("tbl_count", 32'(count), 32'd7);
        checkOutput("tbl_busy",  32'(busy),  32'd0);

        // Stall: three low mem_ack cycles keep the write request stable
        pulseStart();
        mem_ack = 1'b0;
        applyStimulus(vecs[2], 1'b0, "stall");
        for (int i = 0; i < 4; i++) begin
            checkWrite($sformatf("stall%0d", i), 8'd0, 32'h8FA80004);
            checkOutput($sformatf("stall%0d_ready", i), 32'(in_ready), 32'd0);
            if (i == 3) mem_ack = 1'b1;
            @(posedge clk); #1;
        end
        checkOutput("stall_count", 32'(count),    32'd1);
        checkOutput("stall_ready", 32'(in_ready), 32'd1);
        pulseStart();
        applyStimulus(vecs[1], 1'b0, "sess1");
        checkWrite("sess1", 8'd1, 32'h01095100);
        v = vecs[4];
        v.last = 1'b1;
        applyStimulus(v, 1'b0, "sess2");
        checkWrite("sess2", 8'd2, 32'h08000010);
        @(posedge clk); #1;
        checkOutput("sess_done",  32'(done),     32'd1);
        checkOutput("sess_count", 32'(count),    32'd3);
        checkOutput("sess_busy",  32'(busy),     32'd0);
        checkOutput("sess_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("done_hold%0d", i), 32'(done), 32'd1);
        end

        // Illegal format between two legal bundles
        pulseStart();
        checkOutput("ill_done_clr",  32'(done),  32'd0);
        checkOutput("ill_count_clr", 32'(count), 32'd0);
        applyStimulus(vecs[0], 1'b0, "ill_a");
        checkWrite("ill_a", 8'd0, 32'h00221820);
        applyStimulus(bad_v, 1'b0, "ill_bad");
        checkOutput("ill_no_write", 32'(mem_we),   32'd0);
        checkOutput("ill_ready",    32'(in_ready), 32'd1);
        checkOutput("ill_err",      32'(err_fmt),  32'd1);
        v = vecs[2];
        v.last = 1'b1;
        applyStimulus(v, 1'b0, "ill_b");
        checkWrite("ill_b", 8'd1, 32'h8FA80004);
        @(posedge clk); #1;
        checkOutput("ill_done",   32'(done),    32'd1);
        checkOutput("ill_count",  32'(count),   32'd2);
        checkOutput("ill_sticky", 32'(err_fmt), 32'd1);

        // Illegal bundle carrying last ends the session without any write
        pulseStart();
        checkOutput("ill_err_clr", 32'(err_fmt), 32'd0);
        v = bad_v;
        v.last = 1'b1;
        applyStimulus(v, 1'b0, "ill_last");
        checkOutput("ill_last_done",  32'(done),    32'd1);
        checkOutput("ill_last_count", 32'(count),   32'd0);
        checkOutput("ill_last_we",    32'(mem_we),  32'd0);
        checkOutput("ill_last_err",   32'(err_fmt), 32'd1);

        // Reset mid-write: mem_we must drop without waiting for a clock edge
        pulseStart();
        applyStimulus(vecs[0], 1'b0, "mr_a");
        checkWrite("mr_a", 8'd0, 32'h00221820);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        applyStimulus(vecs[1], 1'b0, "mr_b");
        checkWrite("mr_b", 8'd1, 32'h01095100);
        checkOutput("mr_count_pre", 32'(count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mr_we_async",    32'(mem_we), 32'd0);
        checkOutput("mr_count_async", 32'(count),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        checkOutput("mr_idle_ready", 32'(in_ready), 32'd0);
        checkOutput("mr_idle_busy",  32'(busy),     32'd0);
        checkOutput("mr_idle_done",  32'(done),     32'd0);
        checkOutput("mr_idle_count", 32'(count),    32'd0);
        checkOutput("mr_idle_we",    32'(mem_we),   32'd0);

        // Overflow on the 2-bit-address instance: four writes, then the space is exhausted
        pulseStart();
        for (int k = 0; k < 4; k++) begin
            v = vecs[k];
            v.last = 1'b0;
            applyStimulus(v, 1'b1, $sformatf("ov%0d", k));
            checkOutput($sformatf("ov%0d_we", k),    32'(ov_mem_we),   32'd1);
            checkOutput($sformatf("ov%0d_addr", k),  32'(ov_mem_addr), 32'(k));
            checkOutput($sformatf("ov%0d_wdata", k), ov_mem_wdata,     vecs[k].exp_word);
        end
        @(posedge clk); #1;
        checkOutput("ov_done",  32'(ov_done),         32'd1);
        checkOutput("ov_err",   32'(ov_err_overflow), 32'd1);
        checkOutput("ov_count", 32'(ov_count),        32'd4);
        checkOutput("ov_busy",  32'(ov_busy),         32'd0);
        in_fmt = FMT_J; in_op = 6'h02; in_target = 26'h0000010; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ov_fifth_ready%0d", i), 32'(ov_in_ready), 32'd0);
            checkOutput($sformatf("ov_fifth_we%0d", i),    32'(ov_mem_we),   32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checkOutput("ov_count_final", 32'(ov_count), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder counterpart to the control unit's opcode decoder.
- Accepts decoded instruction fields (format, op, rs, rt, rd, shamt, funct, imm, target) over a valid/ready handshake.
- Packs the fields into 32-bit MIPS instruction words and writes them sequentially into instruction memory through a stallable write port.
- Used by the program loader and testbenches to build the program the datapath later fetches and decodes.

Parameters:
- ADDR_W, 8: instruction memory word-address width.
- BASE_ADDR, 0: first word address written after start.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load session; honoured only in IDLE or DONE.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_fmt  in  2  0=R, 1=I, 2=J, 3=illegal.
- in_op  in  6  opcode (ignored for R, forced 6'b000000).
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
- in_funct  in  6  R-type function code.
- in_imm  in  16  I-type immediate.
- in_target  in  26  J-type target.
- in_last  in  1  this bundle ends the session.
- mem_we  out  1  write request; held until mem_ack.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  packed instruction.
- mem_ack  in  1  memory accepted the write this cycle.
- busy  out  1  high in LOAD or WRITE.
- done  out  1  session complete; held until start.
- err_fmt  out  1  sticky: an illegal-format bundle was dropped.
- err_overflow  out  1  sticky: address space exhausted before in_last.
- count  out  ADDR_W+1  words written this session.

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, write pointer=BASE_ADDR. mem_we drops immediately; an in-flight write is abandoned.
- State IDLE: in_ready=0. On start: go to LOAD; clear count, err_fmt, err_overflow and done; set pointer to BASE_ADDR.
- State LOAD: in_ready=1. On in_valid&&in_ready, with fmt 0..2:
  - Latch the packed word into a holding register.
  - Latch in_last.
  - Go to WRITE.
- Illegal format in LOAD (fmt=3):
  - The bundle is consumed.
  - err_fmt is set.
  - Nothing is written; the block stays in LOAD.
  - If in_last is set on the illegal bundle, go to DONE.
- Packing:
  - R = {6'b000000, rs, rt, rd, shamt, funct}.
  - I = {op, rs, rt, imm}.
  - J = {op, target}.
- State WRITE:
  - mem_we=1, mem_addr=pointer, mem_wdata=holding register.
  - All three stay stable until mem_ack. in_ready=0.
  - On mem_ack: count+1, pointer+1 (wraps mod 2^ADDR_W).
  - Then go to DONE if the latched last is set. If the pointer was all-ones and last is clear, go to DONE and set err_overflow. Otherwise go to LOAD.
- State DONE: done=1, in_ready=0. start re-enters LOAD as from IDLE.
- Latency and throughput:
  - Handshake at edge N puts mem_we high in cycle N+1.
  - With mem_ack in that cycle, in_ready is high again in cycle N+2. Peak rate is 1 word per 2 cycles.
  - Each mem_ack stall cycle adds one cycle.
- start asserted in LOAD or WRITE is ignored. in_valid outside LOAD is ignored.
- mem_ack outside WRITE is ignored.
- count saturates naturally: at most 2^ADDR_W, since overflow terminates the session.
- All outputs are registered except in_ready, which is decoded directly from state.

Decomposition:
- Shared package mips_pkg:
  - FMT_R/FMT_I/FMT_J/FMT_BAD constants.
  - OP_RTYPE=6'b000000.
  - Field width constants (OP_W=6, REG_W=5, FUNCT_W=6, IMM_W=16, TGT_W=26).
  - These same constants are used by the control unit.
- One combinational sub-module, instr_pack: fmt + fields -> 32-bit word + illegal flag.
- FSM, pointer and counter stay in instr_encoder.

Test Plan:
- Pack check: start; R bundle rs=1, rt=2, rd=3, shamt=0, funct=6'h20, in_op=6'h3F, with mem_ack tied high. Expect mem_wdata=32'h00221820 (op forced 0) at mem_addr=0, and count=1.
- Stall: I bundle op=6'h23, rs=29, rt=8, imm=16'h0004, with mem_ack held low 3 cycles. Expect mem_we/addr/wdata=32'h8FA80004 stable for 4 cycles and in_ready=0 throughout.
- Session end: three bundles, the third with in_last. Expect J op=2, target=26'h0000010 -> 32'h08000010 at addr 2, then done=1, count=3, busy=0, and done held until the next start.
- Illegal format: fmt=3 bundle between two valid ones. Expect err_fmt=1, only 2 writes to addr 0 and 1, and no gap in addresses.
- Overflow: ADDR_W=2, five bundles with no in_last. Expect 4 writes at addresses 0..3, then DONE with err_overflow=1 and count=4; the fifth bundle is never accepted.
- Reset mid-write: assert rst_n=0 while mem_we=1. Expect mem_we=0 asynchronously, and after release state IDLE, count=0 and done=0.
